// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_pkg : shared encodings for the data-memory port arbiter                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dm_pkg;

  localparam logic [1:0] DM_WORD = 2'd0;
  localparam logic [1:0] DM_HALF = 2'd1;
  localparam logic [1:0] DM_BYTE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WR   = 2'd2
  } dm_state_e;

  localparam logic DM_PORT0 = 1'b0;
  localparam logic DM_PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dm_lane_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_lane_unit : load lane extraction/extension and sub-word store merge     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    unique case (addr_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
    w_half = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Size 3 is reserved and falls through to the word behaviour.
  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    if (size_i == DM_BYTE) begin
      load_o  = {{24{sext_i & w_byte[7]}}, w_byte};
      merge_o = word_i;
      unique case (addr_i)
        2'd0:    merge_o[7:0]   = wdata_i[7:0];
        2'd1:    merge_o[15:8]  = wdata_i[7:0];
        2'd2:    merge_o[23:16] = wdata_i[7:0];
        default: merge_o[31:24] = wdata_i[7:0];
      endcase
    end else if (size_i == DM_HALF) begin
      load_o  = {{16{sext_i & w_half[15]}}, w_half};
      merge_o = word_i;
      if (addr_i[1]) merge_o[31:16] = wdata_i[15:0];
      else           merge_o[15:0]  = wdata_i[15:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_port_arbiter : two-port arbiter for single-port data memory with RMW   |
// | Optional macro DM_ARB_RR_EN selects round-robin instead of fixed priority. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_sext,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_sext,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD,
  output logic              busy
);

  dm_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              port_q, port_d;
  logic [31:0]       merge_q, merge_d;

  logic              w_grant;
  logic              w_pick;
  logic              w_misalign;
  logic              w_oor;
  logic              w_subword;
  logic [31:0]       w_lane_word;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_ack;
  logic              w_err;
  logic [31:0]       w_rdata;

  assign w_grant = (state_q == ST_IDLE) && (p0_req || p1_req);

`ifdef DM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)     last_q <= DM_PORT1;
    else if (w_grant) last_q <= w_pick;
  end

  assign w_pick = (p0_req && p1_req) ? ~last_q : (p1_req ? DM_PORT1 : DM_PORT0);
`else
  assign w_pick = p0_req ? DM_PORT0 : DM_PORT1;
`endif

  assign w_oor     = {2'b00, addr_q[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS);
  assign w_subword = (size_q == DM_HALF) || (size_q == DM_BYTE);

  always_comb begin
    w_misalign = |addr_q[1:0];
    if (size_q == DM_HALF)      w_misalign = addr_q[0];
    else if (size_q == DM_BYTE) w_misalign = 1'b0;
  end

  // Lane unit sees live memory data in ACC and the held old word in WR.
  assign w_lane_word = (state_q == ST_WR) ? merge_q : mem_RD;

  dm_lane_unit u_lane (
    .word_i  (w_lane_word),
    .addr_i  (addr_q[1:0]),
    .size_i  (size_q),
    .sext_i  (sext_q),
    .wdata_i (wdata_q),
    .load_o  (w_load),
    .merge_o (w_merge)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= DM_WORD;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= DM_PORT0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
    merge_d = merge_q;
    w_ack   = 1'b0;
    w_err   = 1'b0;
    w_rdata = '0;
    mem_WE  = 1'b0;
    mem_WD  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_grant) begin
          port_d  = w_pick;
          we_d    = w_pick ? p1_we    : p0_we;
          size_d  = w_pick ? p1_size  : p0_size;
          sext_d  = w_pick ? p1_sext  : p0_sext;
          addr_d  = w_pick ? p1_addr  : p0_addr;
          wdata_d = w_pick ? p1_wdata : p0_wdata;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (w_misalign || w_oor) begin
          w_ack   = 1'b1;
          w_err   = 1'b1;
          state_d = ST_IDLE;
        end else if (!we_q) begin
          w_ack   = 1'b1;
          w_rdata = w_load;
          state_d = ST_IDLE;
        end else if (w_subword) begin
          merge_d = mem_RD;
          state_d = ST_WR;
        end else begin
          mem_WE  = 1'b1;
          mem_WD  = wdata_q;
          w_ack   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        mem_WE  = 1'b1;
        mem_WD  = w_merge;
        w_ack   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_A    = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign p0_ack   = w_ack && (port_q == DM_PORT0);
  assign p0_err   = w_err && (port_q == DM_PORT0);
  assign p0_rdata = (port_q == DM_PORT0) ? w_rdata : '0;
  assign p1_ack   = w_ack && (port_q == DM_PORT1);
  assign p1_err   = w_err && (port_q == DM_PORT1);
  assign p1_rdata = (port_q == DM_PORT1) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dm_port_arbiter : directed vector bench for dm_port_arbiter             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        p0_req, p0_we, p0_sext;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_sext;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE, busy;

  logic [31:0] tb_mem [4096];
  logic        mem_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= 32'h0;
    end else if (mem_WE) begin
      tb_mem[mem_A[13:2]] <= mem_WD;
    end
  end
  assign mem_RD = tb_mem[mem_A[13:2]];

  dm_port_arbiter #(.ADDR_W(32), .MEM_WORDS(4096)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sext(p0_sext),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sext(p1_sext),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .p1_rdata(p1_rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD), .busy(busy)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic we, input logic [1:0] size,
                       input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_we = we; p1_size = size; p1_sext = sext; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_size = size; p0_sext = sext; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic        got, wrote, other, err;
    logic [31:0] rd;
    lat = 0; got = 0; wrote = 0; other = 0; err = 0; rd = '0;
    drive(v.port, v.we, v.size, v.sext, v.addr, v.wdata);
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_WE) wrote = 1'b1;
      if ((v.port ? p0_ack : p1_ack) === 1'b1) other = 1'b1;
      if ((v.port ? p1_ack : p0_ack) === 1'b1) begin
        got = 1'b1;
        lat = c;
        err = v.port ? p1_err : p0_err;
        rd  = v.port ? p1_rdata : p0_rdata;
      end
      @(posedge clk); #1;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check($sformatf("v%0d ack_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, v.exp_err});
    check($sformatf("v%0d other_port_ack", idx), {31'b0, other}, 32'h0);
    if (!v.we || v.exp_err) begin
      check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
      check($sformatf("v%0d no_write", idx), {31'b0, wrote}, 32'h0);
    end
    if (v.chk_mem)
      check($sformatf("v%0d mem_word", idx), tb_mem[v.addr[13:2]], v.exp_mem);
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int   c0, c1;
    logic got;
    logic [31:0] wd_at_p0;
    int   seq[$];

    // port, we, size, sext, addr, wdata, lat, err, rdata, chk_mem, mem
    vecs[0]  = '{0, 1, 2'd0, 0, 32'h10,   32'hDEADBEEF, 2, 0, 32'h0,        1, 32'hDEADBEEF};
    vecs[1]  = '{0, 0, 2'd0, 0, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 2'd0, 0, 32'h20,   32'h11223344, 2, 0, 32'h0,        1, 32'h11223344};
    vecs[3]  = '{0, 1, 2'd2, 0, 32'h22,   32'h000000AA, 3, 0, 32'h0,        1, 32'h11AA3344};
    vecs[4]  = '{0, 1, 2'd1, 0, 32'h20,   32'h0000BEEF, 3, 0, 32'h0,        1, 32'h11AABEEF};
    vecs[5]  = '{0, 0, 2'd1, 1, 32'h20,   32'h0,        2, 0, 32'hFFFFBEEF, 0, 32'h0};
    vecs[6]  = '{0, 0, 2'd2, 0, 32'h22,   32'h0,        2, 0, 32'h000000AA, 0, 32'h0};
    vecs[7]  = '{0, 0, 2'd2, 1, 32'h22,   32'h0,        2, 0, 32'hFFFFFFAA, 0, 32'h0};
    vecs[8]  = '{0, 0, 2'd1, 0, 32'h22,   32'h0,        2, 0, 32'h000011AA, 0, 32'h0};
    vecs[9]  = '{0, 0, 2'd2, 1, 32'h23,   32'h0,        2, 0, 32'h00000011, 0, 32'h0};
    vecs[10] = '{0, 1, 2'd1, 0, 32'h21,   32'h00001234, 2, 1, 32'h0,        1, 32'h11AABEEF};
    vecs[11] = '{0, 0, 2'd0, 0, 32'h4000, 32'h0,        2, 1, 32'h0,        0, 32'h0};
    vecs[12] = '{0, 0, 2'd0, 0, 32'h12,   32'h0,        2, 1, 32'h0,        1, 32'hDEADBEEF};
    vecs[13] = '{1, 0, 2'd0, 0, 32'h20,   32'h0,        2, 0, 32'h11AABEEF, 0, 32'h0};
    vecs[14] = '{1, 1, 2'd2, 0, 32'h21,   32'h00000080, 3, 0, 32'h0,        1, 32'h11AA80EF};
    vecs[15] = '{0, 0, 2'd2, 1, 32'h21,   32'h0,        2, 0, 32'hFFFFFF80, 0, 32'h0};
    vecs[16] = '{0, 0, 2'd3, 0, 32'h20,   32'h0,        2, 0, 32'h11AA80EF, 0, 32'h0};
    vecs[17] = '{0, 1, 2'd2, 0, 32'h4001, 32'h000000FF, 2, 1, 32'h0,        1, 32'h0};
    vecs[18] = '{1, 1, 2'd0, 0, 32'h3FFC, 32'hA5B6C7D8, 2, 0, 32'h0,        1, 32'hA5B6C7D8};
    vecs[19] = '{0, 0, 2'd2, 0, 32'h3FFF, 32'h0,        2, 0, 32'h000000A5, 0, 32'h0};
    vecs[20] = '{1, 1, 2'd0, 0, 32'h40,   32'hCAFEF00D, 2, 0, 32'h0,        1, 32'hCAFEF00D};
    vecs[21] = '{0, 0, 2'd1, 1, 32'h4002, 32'h0,        2, 1, 32'h0,        0, 32'h0};

    Reset_n = 1'b0; mem_clr = 1'b1;
    p0_req = 0; p0_we = 0; p0_size = 0; p0_sext = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_size = 0; p1_sext = 0; p1_addr = 0; p1_wdata = 0;
    repeat (3) @(posedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
    check("reset busy",   {31'b0, busy},   32'h0);
    check("reset mem_WE", {31'b0, mem_WE}, 32'h0);
    check("reset mem_A",  mem_A,           32'h0);
    check("reset mem_WD", mem_WD,          32'h0);
    check("reset p0_ack", {31'b0, p0_ack}, 32'h0);
    check("reset p1_ack", {31'b0, p1_ack}, 32'h0);
    Reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

    // RMW atomicity: p1 word store to the same word arrives while p0's byte RMW is in ACC
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0000009A);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'h12345678);
    p0_req = 1'b0;
    c0 = 0; c1 = 0; wd_at_p0 = '0;
    for (int c = 1; c <= 10 && c1 == 0; c++) begin
      @(negedge clk);
      if (p0_ack === 1'b1 && c0 == 0) begin c0 = c; wd_at_p0 = mem_WD; end
      if (p1_ack === 1'b1) c1 = c;
      @(posedge clk); #1;
    end
    p1_req = 1'b0;
    check("rmw p0 ack cycle", c0, 2);
    check("rmw p0 merged word", wd_at_p0, 32'hCAFEF09A);
    check("rmw p1 ack cycle", c1, 4);
    check("rmw final word", tb_mem[16], 32'h12345678);

    // Reset during the WR cycle of a byte RMW
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h00000055);
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (mem_WE === 1'b1) got = 1'b1;
    end
    check("rst_rmw reached WR", {31'b0, got}, 32'h1);
    Reset_n = 1'b0;
    #1;
    check("rst_rmw mem_WE", {31'b0, mem_WE}, 32'h0);
    check("rst_rmw p0_ack", {31'b0, p0_ack}, 32'h0);
    check("rst_rmw busy",   {31'b0, busy},   32'h0);
    check("rst_rmw mem_WD", mem_WD,          32'h0);
    p0_req = 1'b0;
    @(posedge clk); #1;
    check("rst_rmw ack after edge", {31'b0, p0_ack}, 32'h0);
    check("rst_rmw mem unchanged", tb_mem[12], 32'h0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec(100, '{0, 0, 2'd0, 0, 32'h30, 32'h0, 2, 0, 32'h0, 1, 32'h0});

    // Contention with both ports held
    pulse_reset();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 40 && seq.size() < 10; c++) begin
      @(negedge clk);
      if (p0_ack === 1'b1) seq.push_back(0);
      if (p1_ack === 1'b1) seq.push_back(1);
      @(posedge clk); #1;
    end
    check("contend ack count", seq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < seq.size()) begin
`ifdef DM_ARB_RR_EN
        check($sformatf("contend ack %0d port", i), seq[i], i % 2);
`else
        check($sformatf("contend ack %0d port", i), seq[i], 0);
`endif
      end
    end
    p0_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (p1_ack === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    p1_req = 1'b0;
    check("contend p1 after p0 release", {31'b0, got}, 32'h1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
